// File: rtl/xcore_if_pht_if.sv
// Fetch-side bundle of the gshare PHT: lookup request, commit training and
// the registered prediction handed to the GHR.
interface xcore_if_pht_if #(
    parameter int GHRLEN = 2,
    parameter int IDXW   = 6,
    parameter int PCW    = 32
);
    logic              i_if_req;
    logic [PCW-1:0]    i_if_pc;
    logic [GHRLEN-1:0] i_ghr_val;
    logic              i_flush;
    logic              i_cmt_req;
    logic [IDXW-1:0]   i_cmt_idx;
    logic              i_cmt_target;
    logic              o_bpu_req;
    logic              o_bpu_taken;
    logic [IDXW-1:0]   o_bpu_idx;
    logic [GHRLEN-1:0] o_bpu_ghr;

    modport master (
        output i_if_req, i_if_pc, i_ghr_val, i_flush,
        output i_cmt_req, i_cmt_idx, i_cmt_target,
        input  o_bpu_req, o_bpu_taken, o_bpu_idx, o_bpu_ghr
    );

    modport slave (
        input  i_if_req, i_if_pc, i_ghr_val, i_flush,
        input  i_cmt_req, i_cmt_idx, i_cmt_target,
        output o_bpu_req, o_bpu_taken, o_bpu_idx, o_bpu_ghr
    );
endinterface

// File: rtl/xcore_if_pht.sv
// Gshare pattern history table: PC^GHR hashed lookup of 2-bit saturating
// counters, one-cycle registered prediction, commit-port training.
`ifndef GHRLEN
`define GHRLEN 2
`endif

module xcore_if_pht_ctr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic       tgt_i,
    output logic [1:0] cnt_o,
    output logic [1:0] nxt_o
);
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        nxt_o = cnt_q;
        if (tgt_i) begin
            if (cnt_q != 2'b11) nxt_o = cnt_q + 2'd1;
        end else begin
            if (cnt_q != 2'b00) nxt_o = cnt_q - 2'd1;
        end
        cnt_d = we_i ? nxt_o : cnt_q;
    end

    // Weak not-taken out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= 2'b01;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module xcore_if_pht #(
    parameter int GHRLEN = `GHRLEN,
    parameter int IDXW   = 6,
    parameter int PCW    = 32
) (
    input  logic         i_sys_clk,
    input  logic         i_sys_rst,
    xcore_if_pht_if.slave bus
);
    localparam int NENT = 1 << IDXW;

    typedef struct packed {
        logic              taken;
        logic [IDXW-1:0]   idx;
        logic [GHRLEN-1:0] ghr;
    } pred_t;

    if (IDXW < GHRLEN) begin : g_bad_cfg
        $error("xcore_if_pht: IDXW must be >= GHRLEN");
    end

    logic [NENT-1:0]       we;
    logic [NENT-1:0][1:0]  cnt_all;
    logic [NENT-1:0][1:0]  nxt_all;
    logic [IDXW-1:0]       lkp_idx;
    logic [1:0]            rd_cnt;
    logic                  acc;
    logic                  req_q, req_d;
    pred_t                 pred_q, pred_d;

    for (genvar i = 0; i < NENT; i++) begin : g_ent
        assign we[i] = bus.i_cmt_req && (bus.i_cmt_idx == IDXW'(i));
        xcore_if_pht_ctr u_ctr (
            .clk_i (i_sys_clk),
            .rst_i (i_sys_rst),
            .we_i  (we[i]),
            .tgt_i (bus.i_cmt_target),
            .cnt_o (cnt_all[i]),
            .nxt_o (nxt_all[i])
        );
    end

    assign lkp_idx = bus.i_if_pc[IDXW+1:2] ^ IDXW'(bus.i_ghr_val);
    assign acc     = bus.i_if_req && !bus.i_flush;

    // Write-first: a same-cycle commit to the looked-up entry is forwarded.
    always_comb begin
        rd_cnt = cnt_all[lkp_idx];
        if (bus.i_cmt_req && (bus.i_cmt_idx == lkp_idx)) rd_cnt = nxt_all[lkp_idx];
    end

    always_comb begin
        req_d  = acc;
        pred_d = pred_q;
        if (acc) begin
            pred_d.taken = rd_cnt[1];
            pred_d.idx   = lkp_idx;
            pred_d.ghr   = bus.i_ghr_val;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            req_q  <= 1'b0;
            pred_q <= '0;
        end else begin
            req_q  <= req_d;
            pred_q <= pred_d;
        end
    end

    assign bus.o_bpu_req   = req_q;
    assign bus.o_bpu_taken = pred_q.taken;
    assign bus.o_bpu_idx   = pred_q.idx;
    assign bus.o_bpu_ghr   = pred_q.ghr;
endmodule

// File: doc/xcore_if_pht.md
# xcore_if_pht

Gshare pattern history table for the Xcore instruction-fetch branch predictor. It sits between the fetch PC generator and the global history register. Each cycle it hashes the fetch PC with the current GHR value and looks up a table of 2-bit saturating counters. One cycle later it presents the taken/not-taken prediction as the `i_bpu_req`/`i_bpu_taken` pair the GHR consumes. Commit-stage branch outcomes train the counters through a separate update port.

## Interface
- `GHRLEN`, default 2: global history width; must equal `` `GHRLEN ``.
- `IDXW`, default 6: table index width, giving 2^IDXW counters; `IDXW >= GHRLEN` required.
- `PCW`, default 32: fetch PC width.
- `i_sys_clk`, in, 1: single clock; all state on its rising edge.
- `i_sys_rst`, in, 1: reset, asynchronous, active-high.
- `i_if_req`, in, 1: fetch lookup request, one per cycle max.
- `i_if_pc`, in, PCW: fetch PC of the lookup.
- `i_ghr_val`, in, GHRLEN: current GHR output.
- `i_flush`, in, 1: pipeline redirect; kills the in-flight lookup.
- `i_cmt_req`, in, 1: branch resolved at commit; train the table.
- `i_cmt_idx`, in, IDXW: index carried from the original prediction.
- `i_cmt_target`, in, 1: resolved outcome, 1 = taken.
- `o_bpu_req`, out, 1: prediction valid; drives GHR `i_bpu_req`.
- `o_bpu_taken`, out, 1: predicted direction; drives GHR `i_bpu_taken`.
- `o_bpu_idx`, out, IDXW: index used for this prediction, piped to commit.
- `o_bpu_ghr`, out, GHRLEN: GHR snapshot used for this prediction, piped to commit as the recovery value.

## Operation
- **Index hash:** `idx = i_if_pc[IDXW+1:2] XOR {(IDXW-GHRLEN) zeros, i_ghr_val}`. PC bits [1:0] are ignored.
- **Counter encoding:** 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken. Prediction is counter[1].
- **Lookup:** on `i_if_req`, read counter[idx] and capture idx and `i_ghr_val`.
- **Output registers:** the next cycle presents `o_bpu_taken` = counter[1], `o_bpu_idx`, and `o_bpu_ghr`, with `o_bpu_req` = 1.
- **Idle cycle:** with no request, `o_bpu_req` = 0 next cycle. `o_bpu_taken`, `o_bpu_idx` and `o_bpu_ghr` hold their last values.
- **Update:** on `i_cmt_req`:
  - `i_cmt_target` = 1 increments counter[`i_cmt_idx`], saturating at 11.
  - `i_cmt_target` = 0 decrements it, saturating at 00.
  - Only that one entry changes.
- **Same-cycle read/write collision:** when `i_if_req` and `i_cmt_req` occur together with equal indices, the lookup returns the post-update counter value (write-first bypass).
- **Flush:** `i_flush` in the same cycle as `i_if_req` forces `o_bpu_req` = 0 next cycle.
  - The lookup's idx/ghr capture is also suppressed.
  - `i_flush` never blocks a commit update in the same cycle.
- **Reset:**
  - Every counter resets to 01.
  - `o_bpu_req` = 0, `o_bpu_taken` = 0, `o_bpu_idx` = 0, `o_bpu_ghr` = 0.
  - Reset asserted mid-operation discards the in-flight prediction and all training immediately, without waiting for a clock edge.

## Timing
- **Lookup latency:** exactly 1 cycle from `i_if_req` to `o_bpu_req`. Lookups are fully pipelined, one per cycle, with no stall.
- **Update latency:** a counter write takes effect at the edge following `i_cmt_req`. A lookup of the same index in the next cycle sees the new value.
- **Same-cycle collision:** the bypass makes the write visible to a lookup in the same cycle as the update.
- **Output timing:** all outputs are registered with no combinational input-to-output path.
- **No handshake:** the consumer cannot backpressure. `o_bpu_req` is a single-cycle pulse per accepted lookup.
- **Index hazard:** back-to-back lookups with changing `i_ghr_val` are hashed independently. The block does not wait for the GHR to absorb its own previous prediction.

## Test plan
All scenarios use IDXW = 6 and GHRLEN = 2.

- **Reset state:** after release, lookup PC = 0x0000_0010 with GHR = 00 (idx 4) -> next cycle `o_bpu_req` = 1, `o_bpu_taken` = 0, `o_bpu_idx` = 4, `o_bpu_ghr` = 00.
- **Hash:** PC = 0x0000_001C with GHR = 11 -> `o_bpu_idx` = 7 ^ 3 = 4.
- **Training toward taken:** two commits to idx 4 with target = 1 take counter 01 -> 10 -> 11, so a lookup at idx 4 predicts 1. One commit with target = 0 then gives 10, still predicting 1. A second gives 01, predicting 0.
- **Saturation:**
  - Five taken commits to idx 9 -> counter = 11; one not-taken -> 10, still predicting taken.
  - Four not-taken commits to idx 10 -> counter = 00; one taken -> 01, still predicting not-taken.
- **Collision:** idx 4 holds 01. A commit (idx 4, target = 1) and a lookup of idx 4 in the same cycle -> `o_bpu_taken` = 1 next cycle.
- **Flush and mid-operation reset:**
  - Lookup with `i_flush` high -> `o_bpu_req` = 0 next cycle, and `o_bpu_idx` is unchanged.
  - Assert reset between a lookup and its output edge -> `o_bpu_req` = 0 immediately, and all counters read back as 01.
